// File: rtl/door_pkg.sv
`default_nettype none
// ============================================================================
// Module      : door_pkg
// Description : Shared definitions for the elevator door sequencer: the FSM
//               state encoding and the width of the dwell/travel counters.
// Revision    : 1.0 - initial release
// ============================================================================
package door_pkg;

   // Width of the dwell and travel counters (seconds)
   localparam int CNT_W = 8;

   // State encoding is also exported on the debug 'state' port
   typedef enum logic [2:0] {
      ST_CLOSED  = 3'd0,
      ST_OPENING = 3'd1,
      ST_OPEN    = 3'd2,
      ST_CLOSING = 3'd3,
      ST_FAULT   = 3'd4,
      ST_NUDGE   = 3'd5
   } door_state_e;

endpackage
`default_nettype wire

// File: rtl/door_timer.sv
`default_nettype none
// ============================================================================
// Module      : door_timer
// Description : CNT_W-bit seconds counter with clear, load and tick enable.
//               Counts toward 'target' (down when COUNT_DOWN=1, up otherwise)
//               and stops there; 'done' is high while the count equals target.
// Ports       : clk, reset    - clock, synchronous active-high reset
//               clear         - force count to zero (highest priority)
//               load/load_val - load a start value
//               tick          - advance one step toward target
//               target        - terminal count
//               done          - count == target
// Revision    : 1.0 - initial release
// ============================================================================
module door_timer
   import door_pkg::*;
#(
   parameter bit COUNT_DOWN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             tick,
   input  logic [CNT_W-1:0] target,
   output logic             done
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign done = (count_q == target);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_val;
      end else if (tick && !done) begin
         // Stopping at target doubles as saturation for both directions
         if (COUNT_DOWN) begin
            count_d = count_q - 1'b1;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/door_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : door_sequencer
// Description : Door sequencing FSM for one elevator car. Opens on arrival or
//               open button, holds for a dwell time, reopens on obstruction,
//               times out stuck travel and reports closed-and-locked.
// Build macro : DOOR_NUDGE_EN - when defined, repeated reopens lead to a
//               forced nudge close that ignores the sensor and open button.
// Ports       : clk, reset (sync, active-high), sec_tick (1 Hz pulse)
//               car_stopped, open_req, open_btn, close_btn, door_sensor,
//               open_limit, closed_limit                      - inputs
//               motor_open, motor_close, door_locked, nudge,
//               fault, state[2:0]                             - outputs
// Revision    : 1.0 - initial release
// ============================================================================
module door_sequencer
   import door_pkg::*;
#(
   parameter int DWELL_S     = 15,
   parameter int TRAVEL_S    = 4,
   parameter int NUDGE_LIMIT = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sec_tick,
   input  logic       car_stopped,
   input  logic       open_req,
   input  logic       open_btn,
   input  logic       close_btn,
   input  logic       door_sensor,
   input  logic       open_limit,
   input  logic       closed_limit,
   output logic       motor_open,
   output logic       motor_close,
   output logic       door_locked,
   output logic       nudge,
   output logic       fault,
   output logic [2:0] state
);

   localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_S);
   localparam logic [CNT_W-1:0] TRAVEL_LIM  = CNT_W'(TRAVEL_S);

   // Counters are CNT_W bits wide; reject values that would be truncated
   if (DWELL_S < 0 || DWELL_S > 255 || TRAVEL_S < 0 || TRAVEL_S > 255 ||
       NUDGE_LIMIT < 0 || NUDGE_LIMIT > 255) begin : g_param_check
      $error("door_sequencer: parameter out of 0..255 range");
   end

   door_state_e state_q;
   door_state_e state_d;

   logic dwell_load;
   logic dwell_done;
   logic travel_clear;
   logic travel_done;

`ifdef DOOR_NUDGE_EN
   localparam logic [CNT_W-1:0] NUDGE_LIM = CNT_W'(NUDGE_LIMIT);

   logic [CNT_W-1:0] reopen_cnt_q;
   logic [CNT_W-1:0] reopen_cnt_d;
   logic             nudge_due;

   assign nudge_due = (reopen_cnt_q >= NUDGE_LIM);

   always_comb begin
      reopen_cnt_d = reopen_cnt_q;
      if (state_d == ST_CLOSED && state_q != ST_CLOSED) begin
         reopen_cnt_d = '0;
      end else if (state_q == ST_CLOSING && state_d == ST_OPENING &&
                   reopen_cnt_q != '1) begin
         reopen_cnt_d = reopen_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         reopen_cnt_q <= '0;
      end else begin
         reopen_cnt_q <= reopen_cnt_d;
      end
   end
`endif

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CLOSED: begin
            // Requests without car_stopped are simply dropped
            if (car_stopped && (open_req || open_btn)) begin
               state_d = ST_OPENING;
            end
         end
         ST_OPENING: begin
            // Limit switch is checked first so it beats a same-cycle timeout
            if (open_limit) begin
               state_d = ST_OPEN;
            end else if (travel_done) begin
               state_d = ST_FAULT;
            end
         end
         ST_OPEN: begin
            if (close_btn && !door_sensor) begin
               state_d = ST_CLOSING;
            end else if (dwell_done) begin
`ifdef DOOR_NUDGE_EN
               if (nudge_due) begin
                  state_d = ST_NUDGE;
               end else if (!door_sensor && !open_btn) begin
                  state_d = ST_CLOSING;
               end
`else
               if (!door_sensor && !open_btn) begin
                  state_d = ST_CLOSING;
               end
`endif
            end
         end
         ST_CLOSING: begin
            // Reopen has priority over the closed limit
            if (door_sensor || open_btn) begin
               state_d = ST_OPENING;
            end else if (closed_limit) begin
               state_d = ST_CLOSED;
            end else if (travel_done) begin
               state_d = ST_FAULT;
            end
         end
`ifdef DOOR_NUDGE_EN
         ST_NUDGE: begin
            if (closed_limit) begin
               state_d = ST_CLOSED;
            end else if (travel_done) begin
               state_d = ST_FAULT;
            end
         end
`endif
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_FAULT;
         end
      endcase

      // Car leaving the floor with the door not closed is always a fault
      if (!car_stopped && state_q != ST_CLOSED) begin
         state_d = ST_FAULT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CLOSED;
      end else begin
         state_q <= state_d;
      end
   end

   // Dwell reloads on entry to OPEN and whenever the doorway is in use
   assign dwell_load   = (state_d == ST_OPEN) &&
                         ((state_q != ST_OPEN) || door_sensor || open_btn);
   assign travel_clear = (state_d != state_q) &&
                         ((state_d == ST_OPENING) || (state_d == ST_CLOSING) ||
                          (state_d == ST_NUDGE));

   door_timer #(
      .COUNT_DOWN (1'b1)
   ) u_dwell (
      .clk      (clk),
      .reset    (reset),
      .clear    (1'b0),
      .load     (dwell_load),
      .load_val (DWELL_LOAD),
      .tick     (sec_tick && (state_q == ST_OPEN)),
      .target   ({CNT_W{1'b0}}),
      .done     (dwell_done)
   );

   door_timer #(
      .COUNT_DOWN (1'b0)
   ) u_travel (
      .clk      (clk),
      .reset    (reset),
      .clear    (travel_clear),
      .load     (1'b0),
      .load_val ({CNT_W{1'b0}}),
      .tick     (sec_tick),
      .target   (TRAVEL_LIM),
      .done     (travel_done)
   );

   // ------------------------------------------------------------------------
   // Moore outputs
   // ------------------------------------------------------------------------
   assign motor_open  = (state_q == ST_OPENING);
   assign motor_close = (state_q == ST_CLOSING) || (state_q == ST_NUDGE);
   assign door_locked = (state_q == ST_CLOSED) && closed_limit;
   assign fault       = (state_q == ST_FAULT);
   assign state       = state_q;
`ifdef DOOR_NUDGE_EN
   assign nudge       = (state_q == ST_NUDGE);
`else
   assign nudge       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_door_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_door_sequencer
// Description : Self-checking bench for door_sequencer (DWELL_S=15,
//               TRAVEL_S=4, NUDGE_LIMIT=3). Directed stimulus pushes the
//               expected state into a queue; a monitor on the falling edge
//               pops it and compares all outputs. Nudge scenario runs only
//               when DOOR_NUDGE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_door_sequencer;
   import door_pkg::*;

   logic       clk;
   logic       reset;
   logic       sec_tick;
   logic       car_stopped;
   logic       open_req;
   logic       open_btn;
   logic       close_btn;
   logic       door_sensor;
   logic       open_limit;
   logic       closed_limit;
   logic       motor_open;
   logic       motor_close;
   logic       door_locked;
   logic       nudge;
   logic       fault;
   logic [2:0] state;

   door_sequencer #(
      .DWELL_S     (15),
      .TRAVEL_S    (4),
      .NUDGE_LIMIT (3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sec_tick     (sec_tick),
      .car_stopped  (car_stopped),
      .open_req     (open_req),
      .open_btn     (open_btn),
      .close_btn    (close_btn),
      .door_sensor  (door_sensor),
      .open_limit   (open_limit),
      .closed_limit (closed_limit),
      .motor_open   (motor_open),
      .motor_close  (motor_close),
      .door_locked  (door_locked),
      .nudge        (nudge),
      .fault        (fault),
      .state        (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      door_state_e st;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Expected output vector {state, motor_open, motor_close, door_locked,
   // nudge, fault} for a given state and the current closed_limit input
   function automatic logic [7:0] exp_vec(input door_state_e s, input logic cl);
      return {s,
              (s == ST_OPENING),
              (s == ST_CLOSING) || (s == ST_NUDGE),
              (s == ST_CLOSED) && cl,
              (s == ST_NUDGE),
              (s == ST_FAULT)};
   endfunction

   // Monitor: compares one queued expectation per falling edge
   initial begin
      exp_t       e;
      logic [7:0] got;
      logic [7:0] want;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            got  = {state, motor_open, motor_close, door_locked, nudge, fault};
            want = exp_vec(e.st, closed_limit);
            checks++;
            if (got !== want) begin
               failures++;
               $display("FAIL %s: got {st,mo,mc,lk,ng,ft}=%b want=%b",
                        e.name, got, want);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string n, input door_state_e s);
      exp_t e;
      e.name = n;
      e.st   = s;
      exp_q.push_back(e);
   endtask

   task automatic tick_cyc();
      sec_tick = 1'b1;
      cyc();
      sec_tick = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b1;
      sec_tick     = 1'b0;
      car_stopped  = 1'b0;
      open_req     = 1'b0;
      open_btn     = 1'b0;
      close_btn    = 1'b0;
      door_sensor  = 1'b0;
      open_limit   = 1'b0;
      closed_limit = 1'b1;

      // ---------------- reset state ----------------
      cyc();
      cyc();
      chk("reset_state", ST_CLOSED);
      reset = 1'b0;

      // ---------------- request without car_stopped ----------------
      open_req = 1'b1;
      cyc();
      open_req = 1'b0;
      chk("req_not_stopped", ST_CLOSED);
      car_stopped = 1'b1;
      cyc();
      chk("req_not_remembered", ST_CLOSED);

      // ---------------- normal cycle ----------------
      open_req = 1'b1;
      cyc();
      open_req     = 1'b0;
      closed_limit = 1'b0;
      chk("open_start", ST_OPENING);
      open_limit = 1'b1;
      cyc();
      chk("open_reached", ST_OPEN);
      for (int i = 0; i < 14; i++) begin
         tick_cyc();
         cyc();
         chk("dwell_hold", ST_OPEN);
      end
      tick_cyc();
      cyc();
      chk("dwell_expire", ST_CLOSING);
      open_limit = 1'b0;
      cyc();
      closed_limit = 1'b1;
      chk("closing", ST_CLOSING);
      cyc();
      chk("closed_locked", ST_CLOSED);

      // ---------------- obstruction ----------------
      open_req = 1'b1;
      cyc();
      open_req     = 1'b0;
      closed_limit = 1'b0;
      open_limit   = 1'b1;
      chk("obs_opening", ST_OPENING);
      cyc();
      chk("obs_open", ST_OPEN);
      door_sensor = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick_cyc();
         chk("sensor_hold", ST_OPEN);
      end
      door_sensor = 1'b0;
      cyc();
      for (int i = 0; i < 14; i++) begin
         tick_cyc();
         chk("dwell_reloaded", ST_OPEN);
      end
      close_btn = 1'b1;
      cyc();
      close_btn  = 1'b0;
      open_limit = 1'b0;
      chk("close_btn", ST_CLOSING);
      door_sensor  = 1'b1;
      closed_limit = 1'b1;
      cyc();
      chk("reopen_wins", ST_OPENING);
      door_sensor  = 1'b0;
      closed_limit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick_cyc();
         chk("opening_travel", ST_OPENING);
      end
      sec_tick   = 1'b1;
      open_limit = 1'b1;
      cyc();
      sec_tick = 1'b0;
      chk("limit_beats_timeout", ST_OPEN);
      cyc();
      chk("no_fault_after_limit", ST_OPEN);
      close_btn = 1'b1;
      cyc();
      close_btn  = 1'b0;
      open_limit = 1'b0;
      chk("close_again", ST_CLOSING);
      closed_limit = 1'b1;
      cyc();
      chk("closed_again", ST_CLOSED);

      // ---------------- opening travel timeout ----------------
      open_req = 1'b1;
      cyc();
      open_req     = 1'b0;
      closed_limit = 1'b0;
      chk("to_opening", ST_OPENING);
      for (int i = 0; i < 3; i++) begin
         tick_cyc();
         chk("to_travel", ST_OPENING);
      end
      tick_cyc();
      cyc();
      chk("open_timeout", ST_FAULT);
      open_req     = 1'b1;
      open_btn     = 1'b1;
      closed_limit = 1'b1;
      open_limit   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("fault_hold", ST_FAULT);
      end
      open_req   = 1'b0;
      open_btn   = 1'b0;
      open_limit = 1'b0;
      do_reset();
      chk("fault_reset", ST_CLOSED);

      // ---------------- closing travel timeout ----------------
      open_req = 1'b1;
      cyc();
      open_req     = 1'b0;
      closed_limit = 1'b0;
      open_limit   = 1'b1;
      chk("ct_opening", ST_OPENING);
      cyc();
      close_btn = 1'b1;
      chk("ct_open", ST_OPEN);
      cyc();
      close_btn  = 1'b0;
      open_limit = 1'b0;
      chk("ct_closing", ST_CLOSING);
      for (int i = 0; i < 3; i++) begin
         tick_cyc();
         chk("ct_travel", ST_CLOSING);
      end
      tick_cyc();
      cyc();
      chk("close_timeout", ST_FAULT);
      closed_limit = 1'b1;
      do_reset();
      chk("ct_reset", ST_CLOSED);

      // ---------------- car_stopped lost while OPEN ----------------
      open_req = 1'b1;
      cyc();
      open_req     = 1'b0;
      closed_limit = 1'b0;
      open_limit   = 1'b1;
      chk("cs_opening", ST_OPENING);
      cyc();
      car_stopped = 1'b0;
      chk("cs_open", ST_OPEN);
      cyc();
      chk("car_moved_fault", ST_FAULT);
      car_stopped  = 1'b1;
      open_limit   = 1'b0;
      closed_limit = 1'b1;
      do_reset();
      chk("cs_reset", ST_CLOSED);

      // ---------------- reset mid-travel ----------------
      open_req = 1'b1;
      cyc();
      open_req     = 1'b0;
      closed_limit = 1'b0;
      chk("rm_opening", ST_OPENING);
      do_reset();
      chk("reset_mid_travel", ST_CLOSED);
      closed_limit = 1'b1;
      cyc();
      chk("rm_locked", ST_CLOSED);

`ifdef DOOR_NUDGE_EN
      // ---------------- nudge after repeated reopens ----------------
      open_req = 1'b1;
      cyc();
      open_req     = 1'b0;
      closed_limit = 1'b0;
      open_limit   = 1'b1;
      chk("ng_opening", ST_OPENING);
      cyc();
      chk("ng_open", ST_OPEN);
      for (int r = 0; r < 3; r++) begin
         close_btn = 1'b1;
         cyc();
         close_btn  = 1'b0;
         open_limit = 1'b0;
         chk("ng_closing", ST_CLOSING);
         door_sensor = 1'b1;
         cyc();
         door_sensor = 1'b0;
         open_limit  = 1'b1;
         chk("ng_reopen", ST_OPENING);
         cyc();
         chk("ng_reopened", ST_OPEN);
      end
      for (int i = 0; i < 14; i++) begin
         tick_cyc();
         chk("ng_dwell", ST_OPEN);
      end
      tick_cyc();
      door_sensor = 1'b1;
      cyc();
      open_limit = 1'b0;
      chk("nudge_enter", ST_NUDGE);
      cyc();
      open_btn = 1'b1;
      chk("nudge_ignore_sensor", ST_NUDGE);
      cyc();
      open_btn     = 1'b0;
      door_sensor  = 1'b0;
      closed_limit = 1'b1;
      chk("nudge_ignore_btn", ST_NUDGE);
      cyc();
      chk("nudge_closed", ST_CLOSED);
`endif

      // Drain the scoreboard with a bounded wait
      repeat (4) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
